tx_sync_fifo: RTL and testbench



---
 rtl/tx_sync_fifo_pkg.sv | 20 ++
 rtl/tx_sync_fifo_if.sv | 30 +++
 rtl/tx_sync_fifo_mem.sv | 27 ++
 rtl/tx_sync_fifo.sv | 98 +++++++++
 tb/tb_tx_sync_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tx_sync_fifo_pkg.sv
// Shared definitions for the transmit FIFO: default byte width, pointer
// advance helper and the bit positions of the sticky error flags (these
// positions are reused by the status register map).
package tx_sync_fifo_pkg;

    localparam int unsigned DATA_WD_DEF = 32'd8;
    localparam int unsigned DEPTH_DEF   = 32'd8;

    // Sticky error flag vector layout
    localparam int unsigned ERR_OVF_BIT = 32'd0;
    localparam int unsigned ERR_UDF_BIT = 32'd1;
    localparam int unsigned ERR_WD      = 32'd2;

    // Advance a pointer by one; the caller truncates to PTR_WD+1 bits so the
    // wrap bit toggles naturally when the address bits roll over.
    function automatic logic [31:0] ptr_next(input logic [31:0] ptr);
        return ptr + 32'd1;
    endfunction

endpackage

// File: rtl/tx_sync_fifo_if.sv
// Write/read/status bundle between the system controller, the FIFO and the
// UART transmit controller. "slave" is the FIFO side, "master" the user side.
interface tx_sync_fifo_if #(
    parameter int DATA_WD = 8,
    parameter int DEPTH   = 8
);
    localparam int PTR_WD = $clog2(DEPTH);

    logic [DATA_WD-1:0] WR_D;
    logic               WR_INC;
    logic               FULL;
    logic               ALMOST_FULL;
    logic [DATA_WD-1:0] RD_D;
    logic               RD_INC;
    logic               EMPTY;
    logic [PTR_WD:0]    COUNT;
    logic               ERR_CLR;
    logic               OVF;
    logic               UDF;

    modport slave (
        input  WR_D, WR_INC, RD_INC, ERR_CLR,
        output FULL, ALMOST_FULL, RD_D, EMPTY, COUNT, OVF, UDF
    );

    modport master (
        output WR_D, WR_INC, RD_INC, ERR_CLR,
        input  FULL, ALMOST_FULL, RD_D, EMPTY, COUNT, OVF, UDF
    );
endinterface

// File: rtl/tx_sync_fifo_mem.sv
// Storage array for the transmit FIFO: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem #(
    parameter int DATA_WD = 8,
    parameter int DEPTH   = 8,
    parameter int PTR_WD  = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_WD-1:0]  waddr,
    input  logic [DATA_WD-1:0] wdata,
    input  logic [PTR_WD-1:0]  raddr,
    output logic [DATA_WD-1:0] rdata
);

    logic [DATA_WD-1:0] mem_q [DEPTH];

    // Store the write byte into the addressed slot on an accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tx_sync_fifo.sv
// Single-clock first-word-fall-through byte FIFO between the system controller
// and the UART transmit controller. Flags come only from registered pointers,
// so FULL/EMPTY/COUNT never depend combinationally on WR_INC/RD_INC.
module tx_sync_fifo
    import tx_sync_fifo_pkg::*;
#(
    parameter int DATA_WD  = DATA_WD_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic              CLK,
    input  logic              RST,
    tx_sync_fifo_if.slave     bus
);

    localparam int PTR_WD = $clog2(DEPTH);
    localparam int PW     = PTR_WD + 1;
    localparam logic [PTR_WD:0] AF_LVL_C = PW'(AF_LEVEL);

    logic [PTR_WD:0]    wptr_q, wptr_d;
    logic [PTR_WD:0]    rptr_q, rptr_d;
    logic [ERR_WD-1:0]  err_q, err_d;
    logic [PTR_WD:0]    count_s;
    logic               empty_s;
    logic               full_s;
    logic               wr_acc_s;
    logic               rd_acc_s;
    logic [DATA_WD-1:0] mem_rdata_s;

    // Occupancy flags derived from the start-of-cycle pointer values
    always_comb begin
        empty_s = (wptr_q == rptr_q);
        full_s  = (wptr_q[PTR_WD-1:0] == rptr_q[PTR_WD-1:0]) &&
                  (wptr_q[PTR_WD] != rptr_q[PTR_WD]);
        count_s = wptr_q - rptr_q;
    end

    // Accept/reject decisions, pointer advance and sticky error update
    always_comb begin
        wr_acc_s = bus.WR_INC & ~full_s;
        rd_acc_s = bus.RD_INC & ~empty_s;

        if (wr_acc_s) begin
            wptr_d = PW'(ptr_next(32'(wptr_q)));
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_acc_s) begin
            rptr_d = PW'(ptr_next(32'(rptr_q)));
        end else begin
            rptr_d = rptr_q;
        end

        // A new error in the same cycle as ERR_CLR keeps the flag set
        err_d              = err_q;
        err_d[ERR_OVF_BIT] = (bus.WR_INC & full_s) |
                             (err_q[ERR_OVF_BIT] & ~bus.ERR_CLR);
        err_d[ERR_UDF_BIT] = (bus.RD_INC & empty_s) |
                             (err_q[ERR_UDF_BIT] & ~bus.ERR_CLR);
    end

    // Pointer and error-flag registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
            err_q  <= {ERR_WD{1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            err_q  <= err_d;
        end
    end

    fifo_mem #(
        .DATA_WD (DATA_WD),
        .DEPTH   (DEPTH),
        .PTR_WD  (PTR_WD)
    ) u_mem (
        .clk   (CLK),
        .we    (wr_acc_s),
        .waddr (wptr_q[PTR_WD-1:0]),
        .wdata (bus.WR_D),
        .raddr (rptr_q[PTR_WD-1:0]),
        .rdata (mem_rdata_s)
    );

    // Head byte is forced to zero while empty so stale array contents never leak
    assign bus.RD_D        = empty_s ? {DATA_WD{1'b0}} : mem_rdata_s;
    assign bus.EMPTY       = empty_s;
    assign bus.FULL        = full_s;
    assign bus.COUNT       = count_s;
    assign bus.ALMOST_FULL = (count_s >= AF_LVL_C);
    assign bus.OVF         = err_q[ERR_OVF_BIT];
    assign bus.UDF         = err_q[ERR_UDF_BIT];

endmodule

// File: tb/tb_tx_sync_fifo.sv
// Directed self-checking bench for tx_sync_fifo (DATA_WD=8, DEPTH=8, AF_LEVEL=6).
module tb_tx_sync_fifo;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    tx_sync_fifo_if #(.DATA_WD(8), .DEPTH(8)) bus ();

    tx_sync_fifo #(.DATA_WD(8), .DEPTH(8), .AF_LEVEL(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.WR_INC  = 1'b0;
        bus.RD_INC  = 1'b0;
        bus.ERR_CLR = 1'b0;
        bus.WR_D    = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_checks++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", bus.EMPTY); end
        n_checks++; if (bus.FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.FULL); end
        n_checks++; if (bus.COUNT !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.COUNT); end
        n_checks++; if (bus.OVF !== 1'b0 || bus.UDF !== 1'b0) begin n_fail++; $display("FAIL reset_err got ovf=%b udf=%b exp 0 0", bus.OVF, bus.UDF); end
        n_checks++; if (bus.RD_D !== 8'h00) begin n_fail++; $display("FAIL reset_rdd got %h exp 00", bus.RD_D); end
        n_checks++; if (bus.ALMOST_FULL !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b exp 0", bus.ALMOST_FULL); end
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            bus.WR_INC = 1'b1;
            bus.WR_D   = vals[i];
            tick();
            n_checks++; if (bus.RD_D !== 8'h11 || bus.EMPTY !== 1'b0) begin n_fail++; $display("FAIL basic_fwft[%0d] got rd=%h empty=%b exp 11 0", i, bus.RD_D, bus.EMPTY); end
            n_checks++; if (bus.COUNT !== 4'(i + 1)) begin n_fail++; $display("FAIL basic_count[%0d] got %0d exp %0d", i, bus.COUNT, i + 1); end
        end
        bus.WR_INC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.RD_INC = 1'b1;
            tick();
            if (i < 2) begin
                n_checks++; if (bus.RD_D !== vals[i + 1]) begin n_fail++; $display("FAIL basic_pop[%0d] got %h exp %h", i, bus.RD_D, vals[i + 1]); end
            end else begin
                n_checks++; if (bus.EMPTY !== 1'b1 || bus.COUNT !== 4'd0 || bus.RD_D !== 8'h00) begin n_fail++; $display("FAIL basic_drained got empty=%b cnt=%0d rd=%h exp 1 0 00", bus.EMPTY, bus.COUNT, bus.RD_D); end
            end
        end
        bus.RD_INC = 1'b0;
    endtask

    task automatic test_full_ovf();
        for (int i = 0; i < 8; i++) begin
            bus.WR_INC = 1'b1;
            bus.WR_D   = 8'hA0 + 8'(i);
            tick();
            n_checks++; if (bus.COUNT !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.COUNT, i + 1); end
            n_checks++; if (bus.ALMOST_FULL !== ((i + 1) >= 6)) begin n_fail++; $display("FAIL fill_af[%0d] got %b exp %b", i, bus.ALMOST_FULL, ((i + 1) >= 6)); end
            n_checks++; if (bus.FULL !== ((i + 1) == 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, bus.FULL, ((i + 1) == 8)); end
        end
        n_checks++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf got %b exp 0", bus.OVF); end
        bus.WR_D = 8'hFF;
        tick();
        bus.WR_INC = 1'b0;
        n_checks++; if (bus.OVF !== 1'b1 || bus.COUNT !== 4'd8) begin n_fail++; $display("FAIL ovf_set got ovf=%b cnt=%0d exp 1 8", bus.OVF, bus.COUNT); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (bus.RD_D !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL drain[%0d] got %h exp %h", i, bus.RD_D, 8'hA0 + 8'(i)); end
            bus.RD_INC = 1'b1;
            tick();
        end
        bus.RD_INC = 1'b0;
        n_checks++; if (bus.EMPTY !== 1'b1 || bus.OVF !== 1'b1) begin n_fail++; $display("FAIL drain_end got empty=%b ovf=%b exp 1 1", bus.EMPTY, bus.OVF); end
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        n_checks++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", bus.OVF); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) begin
            bus.WR_INC = 1'b1;
            bus.WR_D   = 8'hC0 + 8'(i);
            tick();
        end
        bus.WR_D   = 8'h55;
        bus.RD_INC = 1'b1;
        tick();
        n_checks++; if (bus.COUNT !== 4'd7 || bus.OVF !== 1'b1 || bus.FULL !== 1'b0) begin n_fail++; $display("FAIL full_rw got cnt=%0d ovf=%b full=%b exp 7 1 0", bus.COUNT, bus.OVF, bus.FULL); end
        n_checks++; if (bus.RD_D !== 8'hC1) begin n_fail++; $display("FAIL full_rw_head got %h exp c1", bus.RD_D); end
        bus.RD_INC = 1'b0;
        tick();
        bus.WR_INC = 1'b0;
        n_checks++; if (bus.COUNT !== 4'd8 || bus.FULL !== 1'b1) begin n_fail++; $display("FAIL refill got cnt=%0d full=%b exp 8 1", bus.COUNT, bus.FULL); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (bus.RD_D !== ((i < 7) ? (8'hC1 + 8'(i)) : 8'h55)) begin n_fail++; $display("FAIL full_rw_drain[%0d] got %h exp %h", i, bus.RD_D, ((i < 7) ? (8'hC1 + 8'(i)) : 8'h55)); end
            bus.RD_INC = 1'b1;
            tick();
        end
        bus.RD_INC  = 1'b0;
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        n_checks++; if (bus.EMPTY !== 1'b1 || bus.OVF !== 1'b0) begin n_fail++; $display("FAIL full_rw_end got empty=%b ovf=%b exp 1 0", bus.EMPTY, bus.OVF); end
    endtask

    task automatic test_empty_rw();
        bus.RD_INC = 1'b1;
        bus.WR_INC = 1'b1;
        bus.WR_D   = 8'h77;
        tick();
        idle_inputs();
        n_checks++; if (bus.UDF !== 1'b1 || bus.COUNT !== 4'd1 || bus.RD_D !== 8'h77) begin n_fail++; $display("FAIL empty_rw got udf=%b cnt=%0d rd=%h exp 1 1 77", bus.UDF, bus.COUNT, bus.RD_D); end
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        n_checks++; if (bus.UDF !== 1'b0 || bus.COUNT !== 4'd1) begin n_fail++; $display("FAIL udf_clr got udf=%b cnt=%0d exp 0 1", bus.UDF, bus.COUNT); end
        bus.RD_INC = 1'b1;
        tick();
        // Underflow in the same cycle as a clear request must win
        bus.ERR_CLR = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (bus.UDF !== 1'b1 || bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL udf_wins got udf=%b empty=%b exp 1 1", bus.UDF, bus.EMPTY); end
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        n_checks++; if (bus.UDF !== 1'b0) begin n_fail++; $display("FAIL udf_clr2 got %b exp 0", bus.UDF); end
    endtask

    task automatic test_wrap_stream();
        logic [7:0] q[$];
        logic [7:0] nv;
        nv = 8'h01;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) begin
                bus.WR_INC = 1'b1;
                bus.WR_D   = nv;
                q.push_back(nv);
                nv = nv + 8'd1;
                tick();
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (bus.RD_D !== q[0]) begin n_fail++; $display("FAIL stream_head[%0d.%0d] got %h exp %h", r, i, bus.RD_D, q[0]); end
                bus.WR_INC = 1'b1;
                bus.RD_INC = 1'b1;
                bus.WR_D   = nv;
                q.push_back(nv);
                void'(q.pop_front());
                nv = nv + 8'd1;
                tick();
                n_checks++; if (bus.COUNT !== 4'd5) begin n_fail++; $display("FAIL stream_count[%0d.%0d] got %0d exp 5", r, i, bus.COUNT); end
            end
            bus.WR_INC = 1'b0;
            for (int i = 0; i < 5; i++) begin
                n_checks++; if (bus.RD_D !== q[0]) begin n_fail++; $display("FAIL wrap_drain[%0d.%0d] got %h exp %h", r, i, bus.RD_D, q[0]); end
                bus.RD_INC = 1'b1;
                void'(q.pop_front());
                tick();
            end
            bus.RD_INC = 1'b0;
            n_checks++; if (bus.EMPTY !== 1'b1 || bus.COUNT !== 4'd0) begin n_fail++; $display("FAIL wrap_empty[%0d] got empty=%b cnt=%0d exp 1 0", r, bus.EMPTY, bus.COUNT); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            bus.WR_INC = 1'b1;
            bus.WR_D   = 8'hE0 + 8'(i);
            tick();
        end
        bus.RD_INC = 1'b1;
        bus.WR_D   = 8'hEE;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        n_checks++; if (bus.EMPTY !== 1'b1 || bus.COUNT !== 4'd0 || bus.RD_D !== 8'h00 || bus.UDF !== 1'b0) begin n_fail++; $display("FAIL mid_reset got empty=%b cnt=%0d rd=%h udf=%b exp 1 0 00 0", bus.EMPTY, bus.COUNT, bus.RD_D, bus.UDF); end
        bus.WR_INC = 1'b1;
        bus.WR_D   = 8'h99;
        tick();
        bus.WR_INC = 1'b0;
        n_checks++; if (bus.RD_D !== 8'h99 || bus.COUNT !== 4'd1) begin n_fail++; $display("FAIL post_reset got rd=%h cnt=%0d exp 99 1", bus.RD_D, bus.COUNT); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_full_ovf();
        test_full_rw();
        test_empty_rw();
        test_wrap_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
